// File: rtl/midi_uart_tx_if.sv
// Byte handshake between the MIDI note sender and the serial transmitter.
// The sender drives the byte and write strobe; the transmitter returns buffer space.
interface midi_uart_tx_if;
   logic [7:0] midi_byte;
   logic       midi_send;
   logic       uart_ready;

   modport master (output midi_byte, output midi_send, input uart_ready);
   modport slave  (input midi_byte, input midi_send, output uart_ready);
endinterface

// File: rtl/midi_uart_tx.sv
// 8N1 MIDI serial transmitter with a small byte FIFO.
// Frames queued bytes back-to-back and flags writes that hit a full FIFO.
module midi_uart_tx #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 31250,
   parameter int unsigned DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   midi_uart_tx_if.slave  bus,
   output logic           tx,
   output logic           busy,
   output logic           overflow
);
   localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
   localparam int unsigned CntW       = $clog2(ClksPerBit);
   localparam int unsigned PtrW       = $clog2(DEPTH);
   localparam logic [CntW-1:0] CntMax   = CntW'(ClksPerBit - 1);
   localparam logic [PtrW:0]   Full     = (PtrW + 1)'(DEPTH);
   localparam logic [PtrW:0]   ReadyMax = (PtrW + 1)'(DEPTH - 2);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q, ovf_d;
   logic [PtrW:0]     count_q, count_d;
   logic [PtrW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [7:0]        mem_q [DEPTH];
   logic              push, pop, wrap;

   assign push = bus.midi_send && (count_q != Full);
   assign wrap = (baud_q == CntMax);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_q];
               baud_d  = '0;
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (wrap) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = 3'd0;
               state_d = StData;
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         StData: begin
            if (wrap) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         StStop: begin
            if (wrap) begin
               baud_d = '0;
               // Next byte starts on the same edge the stop bit ends: no idle gap.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_q];
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_d    = push ? wr_q + PtrW'(1) : wr_q;
      rd_d    = pop ? rd_q + PtrW'(1) : rd_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (bus.midi_send && (count_q == Full));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= bus.midi_byte;
   end

   assign bus.uart_ready = (count_q <= ReadyMax);
   assign tx             = tx_q;
   assign busy           = (state_q != StIdle) || (count_q != '0);
   assign overflow       = ovf_q;
endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: queue-and-timestamp line model checked every cycle,
// plus literal expectations for single byte, Note On, ready, overflow and push/pop.
module tb_midi_uart_tx;
   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int unsigned BAUD   = 125_000;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned N      = CLK_HZ / BAUD;

   logic clk = 1'b0;
   logic rst;
   logic tx, busy, overflow;
   int   errors = 0;
   int   checks = 0;

   midi_uart_tx_if bus ();

   midi_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .tx       (tx),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Line model: a byte queue plus the start time of the frame on the wire.
   logic [7:0]  q_m [$];
   logic [7:0]  sent_log [$];
   logic [7:0]  fbyte;
   bit          active = 1'b0;
   bit          m_ovf = 1'b0;
   bit          started = 1'b0;
   int unsigned cyc = 0;
   int unsigned fstart = 0;
   int unsigned pre;

   always @(posedge clk) begin
      cyc++;
      started = 1'b1;
      if (rst) begin
         q_m.delete();
         active = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         pre = q_m.size();
         if (active && (cyc - fstart == 10 * N)) active = 1'b0;
         if (!active && pre != 0) begin
            fbyte  = q_m.pop_front();
            fstart = cyc;
            active = 1'b1;
            sent_log.push_back(fbyte);
         end
         if (bus.midi_send) begin
            if (pre < DEPTH) q_m.push_back(bus.midi_byte);
            else m_ovf = 1'b1;
         end
      end
   end

   function automatic logic exp_tx();
      int unsigned idx;
      if (!active) return 1'b1;
      idx = (cyc - fstart) / N;
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return fbyte[idx-1];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("model_tx", 32'(tx), 32'(exp_tx()));
         check("model_busy", 32'(busy), 32'(active || q_m.size() != 0));
         check("model_ready", 32'(bus.uart_ready), 32'(q_m.size() <= DEPTH - 2));
         check("model_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2000; i++) begin
         if (!busy) break;
         step();
      end
      check("drain_timeout", 32'(busy), 32'd0);
      step();
   endtask

   logic [9:0] line_bits;
   logic       rdy_prev;

   initial begin
      rst = 1'b1;
      bus.midi_send = 1'b0;
      bus.midi_byte = 8'h00;
      repeat (3) step();
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_ready", 32'(bus.uart_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      step();

      // Single byte 0x90: start, 0,0,0,0,1,0,0,1, stop.
      sent_log.delete();
      line_bits = 10'b11_0010_0000;
      bus.midi_byte = 8'h90;
      bus.midi_send = 1'b1;
      step();
      bus.midi_send = 1'b0;
      check("single_tx_before", 32'(tx), 32'd1);
      step();
      for (int j = 0; j < 80; j++) begin
         check("single_bit", 32'(tx), 32'(line_bits[j/8]));
         if (j == 79) check("single_busy_last", 32'(busy), 32'd1);
         step();
      end
      check("single_busy_end", 32'(busy), 32'd0);
      check("single_log_len", 32'(sent_log.size()), 32'd1);
      check("single_log_byte", 32'(sent_log[0]), 32'h90);
      step();

      // Note On 0x90 0x50 0x64 as three contiguous frames.
      sent_log.delete();
      bus.midi_send = 1'b1;
      bus.midi_byte = 8'h90;
      step();
      bus.midi_byte = 8'h50;
      step();
      bus.midi_byte = 8'h64;
      step();
      bus.midi_send = 1'b0;
      check("note_ready", 32'(bus.uart_ready), 32'd1);
      repeat (238) step();
      check("note_busy_240", 32'(busy), 32'd1);
      step();
      check("note_busy_241", 32'(busy), 32'd0);
      check("note_overflow", 32'(overflow), 32'd0);
      check("note_log_0", 32'(sent_log[0]), 32'h90);
      check("note_log_1", 32'(sent_log[1]), 32'h50);
      check("note_log_2", 32'(sent_log[2]), 32'h64);
      step();

      // Write landing on the stop-bit-end edge while one byte is queued.
      sent_log.delete();
      bus.midi_send = 1'b1;
      bus.midi_byte = 8'hA5;
      step();
      bus.midi_byte = 8'h3C;
      step();
      bus.midi_send = 1'b0;
      repeat (79) step();
      bus.midi_send = 1'b1;
      bus.midi_byte = 8'hC3;
      step();
      bus.midi_send = 1'b0;
      check("pp_tx_start", 32'(tx), 32'd0);
      check("pp_ready", 32'(bus.uart_ready), 32'd1);
      drain();
      check("pp_log_len", 32'(sent_log.size()), 32'd3);
      check("pp_log_0", 32'(sent_log[0]), 32'hA5);
      check("pp_log_1", 32'(sent_log[1]), 32'h3C);
      check("pp_log_2", 32'(sent_log[2]), 32'hC3);

      // Six back-to-back writes: five survive, the sixth overflows.
      sent_log.delete();
      for (int i = 1; i <= 6; i++) begin
         bus.midi_byte = 8'(i);
         bus.midi_send = 1'b1;
         step();
         if (i == 3) check("ovf_ready_hi", 32'(bus.uart_ready), 32'd1);
         if (i == 4) check("ovf_ready_lo", 32'(bus.uart_ready), 32'd0);
      end
      bus.midi_send = 1'b0;
      check("ovf_set", 32'(overflow), 32'd1);
      drain();
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_log_len", 32'(sent_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("ovf_log", 32'(sent_log[i]), 32'(i + 1));

      // Compliant sender: acts on uart_ready sampled one cycle earlier.
      rdy_prev = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         bus.midi_send = rdy_prev && ($urandom_range(0, 3) == 0);
         bus.midi_byte = 8'($urandom);
         rdy_prev = bus.uart_ready;
         step();
      end
      // Unconstrained writes to hit the full-FIFO path.
      for (int i = 0; i < 400; i++) begin
         bus.midi_send = ($urandom_range(0, 1) == 0);
         bus.midi_byte = 8'($urandom);
         step();
      end
      bus.midi_send = 1'b0;
      step();

      // Reset mid-traffic aborts the frame and clears everything.
      rst = 1'b1;
      step();
      check("midrst_tx", 32'(tx), 32'd1);
      check("midrst_ready", 32'(bus.uart_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      repeat (2) step();
      rst = 1'b0;
      repeat (100) step();
      check("post_rst_tx", 32'(tx), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

MIDI serial transmitter that consumes the byte stream produced by the note sender (`midi_byte` / `midi_send` / `uart_ready`) and drives the MIDI OUT line at 31250 baud, 8N1. A small byte FIFO absorbs the sender's registered, one-cycle-late write strobe, so a 3-byte Note On message is never lost while a previous frame is still shifting out. Sits between `midi_note_sender` and the board's TX pin.

## Interface

- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 31250: line rate. `CLKS_PER_BIT = CLK_HZ / BAUD`, integer division, giving 1600 at the defaults. Must be ≥ 2.
- `DEPTH`, default 4: FIFO depth in bytes. Power of two, ≥ 2.

- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `midi_byte`  in  8  byte to transmit, qualified by `midi_send`.
- `midi_send`  in  1  one-cycle write strobe.
- `uart_ready`  out  1  high when the FIFO has at least 2 free entries.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `overflow`  out  1  sticky; set when a write hits a full FIFO, cleared only by `rst`.

## Operation

- **Reset:** applies on a `clk` edge with `rst` high.
  - Outputs: `tx`=1, `uart_ready`=1, `busy`=0, `overflow`=0.
  - Internal: FIFO count, read pointer and write pointer = 0; FSM = IDLE; bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame. `tx` returns high on that edge, and FIFO contents are discarded.
- **FIFO:**
  - A write occurs on any edge where `midi_send`=1 and count < DEPTH. The byte goes in at the write pointer.
  - If `midi_send`=1 and count = DEPTH, the byte is dropped, `overflow` is set, and the pointers do not change.
  - Write and pop on the same edge: count is unchanged, and both pointers advance modulo DEPTH.
- **`uart_ready`:** combinational, `count <= DEPTH-2`.
  - The upstream sender samples `uart_ready` and asserts `midi_send` one cycle later. It can therefore issue one more write after `uart_ready` falls; the 2-slot margin covers that write.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If count > 0, pop the head into the shift register, clear the baud counter, drive `tx`=0 and go to START.
  - START: hold `tx`=0 for CLKS_PER_BIT cycles. Then drive `tx`=shift[0] and go to DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles. Bits go out LSB first: shift right, bit index +1. After bit 7 completes, drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
    - If count > 0, pop, drive `tx`=0 and go to START. This is back-to-back with no idle gap.
    - Otherwise go to IDLE.
- **Baud counter:** width is `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1, then wraps to 0, and the bit boundary occurs on the wrap. No fractional-baud correction; the integer divide is exact at the defaults.
- **`busy`:** `(state != IDLE) || (count != 0)`.
- Data bytes are sent verbatim. The block does not interpret MIDI status and does not apply running status.

## Timing

- Write on edge k into an empty FIFO with the FSM in IDLE:
  - `tx` falls after edge k+1.
  - `uart_ready` is unaffected when DEPTH ≥ 4.
- One frame is 10 × CLKS_PER_BIT cycles. At the defaults that is 16000 cycles, 320 µs.
- Each bit, start and stop included, is exactly CLKS_PER_BIT cycles, measured between `tx` transitions.
- Consecutive FIFO bytes produce contiguous frames. The stop bit of byte n ends on the same edge that the start bit of byte n+1 begins.
- Throughput is one byte per 10 × CLKS_PER_BIT cycles. The FIFO never drains faster than this.

## Test plan

Benches use `CLK_HZ`=1_000_000 and `BAUD`=125_000, so CLKS_PER_BIT=8, with DEPTH=4 unless noted.

1. **Reset:** assert `rst` for 3 cycles mid-traffic → `tx`=1, `uart_ready`=1, `busy`=0 and `overflow`=0 on the edge after `rst`; no further frame appears.
2. **Single byte:** single write of 0x90 → `tx` low after the next edge, then line bits 0,0,0,0,0,1,0,0,1,1 (start, data LSB first, stop), each exactly 8 cycles; `busy` falls after 80 cycles.
3. **Note On via sender:** drive `midi_note_sender` with `distance_cm`=5 and strobe `distance_ready` → three contiguous frames 0x90, 0x50, 0x64; no idle gap; 240 cycles total; `overflow`=0.
4. **Ready timing:** 3 writes on consecutive cycles into an empty FIFO → after the first pop, count = 2 and `uart_ready`=1; `uart_ready` falls once count reaches 3.
5. **Overflow:** 6 writes on consecutive cycles (0x01..0x06) while the FIFO is empty and `tx` idle → 0x01..0x05 are transmitted (one popped immediately, four buffered); 0x06 is dropped; `overflow`=1 and stays 1 until `rst`.
6. **Simultaneous push and pop:** write exactly on the stop-bit-end edge with count = 1 → count stays 1; the next frame starts back-to-back; the written byte follows in FIFO order.
